sram_phy_ctrl: RTL and testbench
================================

Name: sram_phy_ctrl

Overview:
- Single-word controller between the SRAM line-burst wrapper and the three 16-bit asynchronous SRAM chips that form the 48-bit data path.
- Accepts one 48-bit read or masked write per request, using a registered NAK handshake that runs in lockstep with the burst wrapper.
- Generates the per-chip CE/OE/WE/UB/LB strobes with programmable access timing.
- Owns the tri-state data bus.

Parameters:
RD_CYCLES, 2, cycles OE is held low before read data is sampled (legal range 1..15)
WR_CYCLES, 2, cycles WE is held low per write (legal range 1..15)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active low
wb_stb  input  1  request valid; held high by the master while it has a request
wb_addr  input  32  byte address; bits [21:2] are the word address; others are ignored
wb_we  input  6  byte-write mask; 0 = read; nonzero = write; bit i enables wb_din[8i+7:8i]
wb_din  input  48  write data
wb_dout  output  48  read data from the most recent completed read
wb_nak  output  1  registered busy flag
sram_ce_n  output  3  chip enable per chip; chip j carries data bits [16j+15:16j]
sram_oe_n  output  3  output enable per chip
sram_we_n  output  3  write enable per chip
sram_ub_n  output  3  upper-byte enable per chip; chip j maps to mask bit 2j+1
sram_lb_n  output  3  lower-byte enable per chip; chip j maps to mask bit 2j
sram_addr  output  20  word address to all chips
sram_data  inout  48  SRAM data bus; driven only in write states, otherwise Z

Behaviour:
- Reset (edge with rst_n=0), which takes priority over everything including an in-progress access:
  - state IDLE; wb_nak=0; wb_dout=0; sram_addr=0.
  - All *_n outputs = 3'b111; sram_data released to Z.
  - An aborted write never leaves sram_we_n low past the reset edge.
- Acceptance:
  - A request is accepted on any edge where wb_stb=1 and wb_nak=0 (the registered value before the edge). This happens only in IDLE.
  - On that edge: wb_nak<=1; latch wb_addr[21:2] into sram_addr, wb_we into a mask register, wb_din into a write-data register.
  - The master changes address/data only on edges where it sees wb_nak=0, so each request is accepted exactly once.
  - wb_stb=0 in IDLE: outputs stay inactive, no state change.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD. A 4-bit cycle counter is cleared on every state entry.
- Read (mask==0):
  - Accept edge: IDLE->RD; ce_n=000, oe_n=000, ub_n=lb_n=000, we_n=111.
  - Each RD edge increments the counter.
  - On the edge where counter==RD_CYCLES-1: wb_dout<=sram_data; wb_nak<=0; all *_n<=111; ->IDLE.
  - wb_nak is high for exactly RD_CYCLES cycles.
- Write (mask!=0):
  - Accept edge: ->WR_SETUP; the bus drives the latched write data.
  - Chip j is enabled (ce_n[j]=0) only if mask[2j+1:2j]!=0; ub_n[j]=~mask[2j+1]; lb_n[j]=~mask[2j]; oe_n=111.
  - WR_SETUP: 1 cycle with we_n=111, then ->WR_PULSE.
  - WR_PULSE: we_n[j]=ce_n[j] for WR_CYCLES cycles, then ->WR_HOLD with we_n=111.
  - WR_HOLD: data, ce and address held 1 cycle.
  - On the next edge: wb_nak<=0, bus to Z, all *_n<=111, ->IDLE.
  - wb_nak is high for WR_CYCLES+2 cycles. wb_dout is unchanged by writes.
- Turnaround: after any completion the controller spends at least one cycle in IDLE with all strobes inactive before the next access. This guarantees bus turnaround between write and read.
- wb_dout holds its value until the next read completes.

Test Plan:
- Reset mid-write:
  - Stimulus: write accepted, then rst_n=0 during WR_PULSE.
  - Required: next edge gives we_n=111, ce_n=111, sram_data=Z, wb_nak=0, state IDLE; the following wb_stb is accepted normally.
- Single read, RD_CYCLES=2:
  - Stimulus: wb_addr=0x0000_0010, wb_we=0; SRAM model returns 48'h0000_1234_5678.
  - Required: sram_addr=0x00004; oe_n=000 for 2 cycles; wb_nak high 2 cycles; then wb_dout=48'h0000_1234_5678.
- Masked write, WR_CYCLES=2:
  - Stimulus: wb_we=6'b000011, wb_din=48'hAAAA_BBBB_CCCC, addr 0x8.
  - Required: only chip0 has ce_n=0, with ub_n[0]=lb_n[0]=0; we_n[0] low exactly 2 cycles; we_n[2:1]=11 throughout; the model stores 16'hCCCC at word 2 in chip0 only; wb_nak high 4 cycles.
- Partial byte write:
  - Stimulus: wb_we=6'b100000.
  - Required: ce_n=011, ub_n[2]=0, lb_n[2]=1; only byte 5 is changed in the model.
- Lockstep burst:
  - Stimulus: wb_stb held high, address advanced by 4 on each wb_nak=0 edge, 16 reads of addresses 0..0x3C holding pattern k.
  - Required: exactly 16 acceptances; sram_addr steps 0..15; wb_dout=k after completion k; no address accepted twice.
- Read after write:
  - Stimulus: write 48'h1111_2222_3333 at word 5, then read word 5 back-to-back.
  - Required: at least one IDLE cycle with all strobes high and sram_data=Z between the accesses; readback = 48'h1111_2222_3333.

Source files
------------

// File: rtl/sram_phy_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_phy_ctrl
//  Brief    : Single-word 48-bit controller for three 16-bit async SRAMs with
//             registered NAK handshake and programmable strobe timing.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_phy_ctrl #(
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_stb,
    input  logic [31:0] wb_addr,
    input  logic [5:0]  wb_we,
    input  logic [47:0] wb_din,
    output logic [47:0] wb_dout,
    output logic        wb_nak,
    output logic [2:0]  sram_ce_n,
    output logic [2:0]  sram_oe_n,
    output logic [2:0]  sram_we_n,
    output logic [2:0]  sram_ub_n,
    output logic [2:0]  sram_lb_n,
    output logic [19:0] sram_addr,
    inout  wire  [47:0] sram_data
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
    } state_t;

    localparam logic [3:0] c_RD_LAST = 4'(RD_CYCLES - 1);
    localparam logic [3:0] c_WR_LAST = 4'(WR_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [5:0]  r_mask;
    logic [47:0] r_wdata;
    logic [47:0] r_dout;
    logic [19:0] r_addr;
    logic        r_nak;
    logic        r_drive;
    logic [2:0]  r_ce_n;
    logic [2:0]  r_oe_n;
    logic [2:0]  r_we_n;
    logic [2:0]  r_ub_n;
    logic [2:0]  r_lb_n;

    logic [2:0]  w_req_ce_n;
    logic [2:0]  w_mask_ce_n;
    logic        w_unused_addr;

    // A chip takes part in a write only if at least one of its two bytes is masked in
    for (genvar j = 0; j < 3; j++) begin : g_chip
        assign w_req_ce_n[j]  = ~|wb_we[2*j +: 2];
        assign w_mask_ce_n[j] = ~|r_mask[2*j +: 2];
    end

    assign w_unused_addr = ^{wb_addr[31:22], wb_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_mask  <= 6'd0;
            r_wdata <= 48'd0;
            r_dout  <= 48'd0;
            r_addr  <= 20'd0;
            r_nak   <= 1'b0;
            r_drive <= 1'b0;
            r_ce_n  <= 3'b111;
            r_oe_n  <= 3'b111;
            r_we_n  <= 3'b111;
            r_ub_n  <= 3'b111;
            r_lb_n  <= 3'b111;
        end else begin
            case (r_state)
                IDLE: begin
                    if (wb_stb && !r_nak) begin
                        r_nak   <= 1'b1;
                        r_addr  <= wb_addr[21:2];
                        r_mask  <= wb_we;
                        r_wdata <= wb_din;
                        r_cnt   <= 4'd0;
                        if (wb_we == 6'd0) begin
                            r_state <= RD;
                            r_ce_n  <= 3'b000;
                            r_oe_n  <= 3'b000;
                            r_ub_n  <= 3'b000;
                            r_lb_n  <= 3'b000;
                        end else begin
                            r_state <= WR_SETUP;
                            r_drive <= 1'b1;
                            r_ce_n  <= w_req_ce_n;
                            r_ub_n  <= ~{wb_we[5], wb_we[3], wb_we[1]};
                            r_lb_n  <= ~{wb_we[4], wb_we[2], wb_we[0]};
                        end
                    end
                end
                RD: begin
                    if (r_cnt == c_RD_LAST) begin
                        r_dout  <= sram_data;
                        r_nak   <= 1'b0;
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                        r_ce_n  <= 3'b111;
                        r_oe_n  <= 3'b111;
                        r_ub_n  <= 3'b111;
                        r_lb_n  <= 3'b111;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                WR_SETUP: begin
                    r_state <= WR_PULSE;
                    r_cnt   <= 4'd0;
                    r_we_n  <= w_mask_ce_n;
                end
                WR_PULSE: begin
                    if (r_cnt == c_WR_LAST) begin
                        r_state <= WR_HOLD;
                        r_cnt   <= 4'd0;
                        r_we_n  <= 3'b111;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                WR_HOLD: begin
                    r_nak   <= 1'b0;
                    r_drive <= 1'b0;
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                    r_ce_n  <= 3'b111;
                    r_oe_n  <= 3'b111;
                    r_we_n  <= 3'b111;
                    r_ub_n  <= 3'b111;
                    r_lb_n  <= 3'b111;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                    r_nak   <= 1'b0;
                    r_drive <= 1'b0;
                    r_ce_n  <= 3'b111;
                    r_oe_n  <= 3'b111;
                    r_we_n  <= 3'b111;
                    r_ub_n  <= 3'b111;
                    r_lb_n  <= 3'b111;
                end
            endcase
        end
    end

    assign sram_data = r_drive ? r_wdata : {48{1'bz}};

    assign wb_dout   = r_dout;
    assign wb_nak    = r_nak;
    assign sram_addr = r_addr;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;
    assign sram_ub_n = r_ub_n;
    assign sram_lb_n = r_lb_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_phy_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_phy_ctrl
//  Brief    : Directed-vector bench for sram_phy_ctrl with a 3-chip SRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_phy_ctrl;

    localparam int RD_CYCLES = 2;
    localparam int WR_CYCLES = 2;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        wb_stb  = 1'b0;
    logic [31:0] wb_addr = 32'd0;
    logic [5:0]  wb_we   = 6'd0;
    logic [47:0] wb_din  = 48'd0;
    logic [47:0] wb_dout;
    logic        wb_nak;
    logic [2:0]  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [19:0] sram_addr;
    wire  [47:0] sram_data;

    logic [47:0] mem [64];
    int          load_mode = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [5:0]  we;
        logic [47:0] din;
        logic [19:0] sa;
        logic [2:0]  ce;
        logic [2:0]  ub;
        logic [2:0]  lb;
        int          nak;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs [8];

    int          m_nak, m_oe_low, m_we_low;
    logic [2:0]  m_we_and, m_ce, m_ub, m_lb;
    logic [19:0] m_sa;

    always #5 clk = ~clk;

    sram_phy_ctrl #(
        .RD_CYCLES(RD_CYCLES),
        .WR_CYCLES(WR_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_stb    (wb_stb),
        .wb_addr   (wb_addr),
        .wb_we     (wb_we),
        .wb_din    (wb_din),
        .wb_dout   (wb_dout),
        .wb_nak    (wb_nak),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n),
        .sram_addr (sram_addr),
        .sram_data (sram_data)
    );

    // SRAM chips drive their slice only while selected, output-enabled and not writing
    for (genvar j = 0; j < 3; j++) begin : g_model
        assign sram_data[16*j +: 16] = (!sram_ce_n[j] && !sram_oe_n[j] && sram_we_n[j])
                                       ? mem[sram_addr[5:0]][16*j +: 16] : {16{1'bz}};
    end

    always @(posedge clk) begin
        if (load_mode == 1) begin
            for (int k = 0; k < 64; k++) mem[k] = 48'h5555_6666_7777;
            mem[4] = 48'h0000_1234_5678;
        end else if (load_mode == 2) begin
            for (int k = 0; k < 64; k++) mem[k] = 48'(k);
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (!sram_ce_n[j] && !sram_we_n[j]) begin
                    if (!sram_ub_n[j]) mem[sram_addr[5:0]][16*j+8 +: 8] = sram_data[16*j+8 +: 8];
                    if (!sram_lb_n[j]) mem[sram_addr[5:0]][16*j +: 8]   = sram_data[16*j +: 8];
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_strobes"}, {49'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
              {49'd0, 15'h7fff});
        check({name, "_bus_z"}, {16'd0, sram_data}, {16'd0, {48{1'bz}}});
    endtask

    task automatic load(input int mode);
        load_mode = mode;
        @(negedge clk);
        load_mode = 0;
    endtask

    // Called on a falling edge with wb_nak low; returns on the first falling edge
    // after completion, leaving wb_stb asserted so the caller can chain requests.
    task automatic access(input logic [31:0] a, input logic [5:0] m, input logic [47:0] d);
        bit first;
        first    = 1'b1;
        wb_stb   = 1'b1;
        wb_addr  = a;
        wb_we    = m;
        wb_din   = d;
        m_nak    = 0;
        m_oe_low = 0;
        m_we_low = 0;
        m_we_and = 3'b111;
        m_ce     = 3'bxxx;
        m_ub     = 3'bxxx;
        m_lb     = 3'bxxx;
        m_sa     = 20'hxxxxx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!wb_nak) break;
            m_nak++;
            if (first) begin
                m_ce  = sram_ce_n;
                m_ub  = sram_ub_n;
                m_lb  = sram_lb_n;
                m_sa  = sram_addr;
                first = 1'b0;
            end
            if (sram_oe_n != 3'b111) m_oe_low++;
            if (sram_we_n != 3'b111) m_we_low++;
            m_we_and = m_we_and & sram_we_n;
        end
    endtask

    initial begin
        logic [47:0] dout_before;
        int issued, done, accepts, addr_err;
        bit prev_nak;

        vecs[0] = '{32'h0000_0010, 6'b000000, 48'h0,             20'h4, 3'b000, 3'b000, 3'b000, 2, 48'h0000_1234_5678};
        vecs[1] = '{32'h0000_0008, 6'b000011, 48'hAAAA_BBBB_CCCC, 20'h2, 3'b110, 3'b110, 3'b110, 4, 48'h5555_6666_CCCC};
        vecs[2] = '{32'h0000_000C, 6'b100000, 48'h9988_7766_5544, 20'h3, 3'b011, 3'b011, 3'b111, 4, 48'h9955_6666_7777};
        vecs[3] = '{32'h0000_0008, 6'b000000, 48'h0,             20'h2, 3'b000, 3'b000, 3'b000, 2, 48'h5555_6666_CCCC};
        vecs[4] = '{32'h0000_000C, 6'b000000, 48'h0,             20'h3, 3'b000, 3'b000, 3'b000, 2, 48'h9955_6666_7777};
        vecs[5] = '{32'h0000_001C, 6'b010100, 48'h0102_0304_0506, 20'h7, 3'b001, 3'b111, 3'b001, 4, 48'h5502_6604_7777};
        vecs[6] = '{32'hFFC0_001C, 6'b000000, 48'h0,             20'h7, 3'b000, 3'b000, 3'b000, 2, 48'h5502_6604_7777};
        vecs[7] = '{32'h0000_0018, 6'b111111, 48'hFEDC_BA98_7654, 20'h6, 3'b000, 3'b000, 3'b000, 4, 48'hFEDC_BA98_7654};

        repeat (3) @(negedge clk);
        check("rst_nak", {63'd0, wb_nak}, 64'd0);
        check("rst_dout", {16'd0, wb_dout}, 64'd0);
        check("rst_addr", {44'd0, sram_addr}, 64'd0);
        check_idle("rst");
        load(1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_stb_nak", {63'd0, wb_nak}, 64'd0);
        check_idle("idle_no_stb");

        foreach (vecs[v]) begin
            dout_before = wb_dout;
            access(vecs[v].addr, vecs[v].we, vecs[v].din);
            check($sformatf("v%0d_sram_addr", v), {44'd0, m_sa}, {44'd0, vecs[v].sa});
            check($sformatf("v%0d_ce_n", v), {61'd0, m_ce}, {61'd0, vecs[v].ce});
            check($sformatf("v%0d_ub_n", v), {61'd0, m_ub}, {61'd0, vecs[v].ub});
            check($sformatf("v%0d_lb_n", v), {61'd0, m_lb}, {61'd0, vecs[v].lb});
            check($sformatf("v%0d_nak_cycles", v), 64'(m_nak), 64'(vecs[v].nak));
            if (vecs[v].we == 6'd0) begin
                check($sformatf("v%0d_oe_low", v), 64'(m_oe_low), 64'(RD_CYCLES));
                check($sformatf("v%0d_we_low", v), 64'(m_we_low), 64'd0);
                check($sformatf("v%0d_rdata", v), {16'd0, wb_dout}, {16'd0, vecs[v].exp});
            end else begin
                check($sformatf("v%0d_we_low", v), 64'(m_we_low), 64'(WR_CYCLES));
                check($sformatf("v%0d_oe_low", v), 64'(m_oe_low), 64'd0);
                check($sformatf("v%0d_we_chips", v), {61'd0, m_we_and}, {61'd0, vecs[v].ce});
                check($sformatf("v%0d_mem", v), {16'd0, mem[vecs[v].sa[5:0]]}, {16'd0, vecs[v].exp});
                check($sformatf("v%0d_dout_kept", v), {16'd0, wb_dout}, {16'd0, dout_before});
            end
            check_idle($sformatf("v%0d_turn", v));
        end
        wb_stb = 1'b0;

        // Lockstep burst: stb held, address advanced on each nak-low edge
        load(2);
        issued = 0; done = 0; accepts = 0; addr_err = 0; prev_nak = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (wb_nak && !prev_nak) accepts++;
            if (wb_nak && sram_addr != 20'(issued - 1)) addr_err++;
            if (!wb_nak) begin
                if (issued > 0 && prev_nak) begin
                    check($sformatf("burst_dout%0d", issued - 1), {16'd0, wb_dout}, 64'(issued - 1));
                    done++;
                end
                if (issued == 16) begin
                    wb_stb = 1'b0;
                    break;
                end
                wb_stb  = 1'b1;
                wb_we   = 6'd0;
                wb_addr = 32'(issued * 4);
                issued++;
            end
            prev_nak = wb_nak;
            @(negedge clk);
        end
        wb_stb = 1'b0;
        check("burst_accepts", 64'(accepts), 64'd16);
        check("burst_done", 64'(done), 64'd16);
        check("burst_addr_err", 64'(addr_err), 64'd0);

        // Read after write, back to back
        access(32'h14, 6'b111111, 48'h1111_2222_3333);
        check("raw_w_nak", 64'(m_nak), 64'd4);
        check("raw_mem", {16'd0, mem[5]}, {16'd0, 48'h1111_2222_3333});
        check_idle("raw_turn");
        access(32'h14, 6'b000000, 48'h0);
        check("raw_r_nak", 64'(m_nak), 64'd2);
        check("raw_rdata", {16'd0, wb_dout}, {16'd0, 48'h1111_2222_3333});
        wb_stb = 1'b0;
        @(negedge clk);

        // Reset in the middle of a write pulse
        wb_stb  = 1'b1;
        wb_addr = 32'h24;
        wb_we   = 6'b111111;
        wb_din  = 48'hCAFE_F00D_BEEF;
        @(negedge clk);
        wb_stb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (sram_we_n != 3'b111) break;
            @(negedge clk);
        end
        check("mw_pulse_reached", {61'd0, sram_we_n}, 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mw_nak", {63'd0, wb_nak}, 64'd0);
        check("mw_dout", {16'd0, wb_dout}, 64'd0);
        check_idle("mw");
        rst_n = 1'b1;
        @(negedge clk);
        access(32'h4, 6'b000000, 48'h0);
        wb_stb = 1'b0;
        check("mw_after_nak", 64'(m_nak), 64'd2);
        check("mw_after_addr", {44'd0, m_sa}, 64'd1);
        check("mw_after_rdata", {16'd0, wb_dout}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
